alu_seq: RTL and testbench

Registered, multi-cycle successor to the combinational ALU of the Salamander-4 datapath. It adds a 4-bit opcode space with shifts and rotates, plus iterative unsigned multiply and divide. Status flags are registered. A start/busy/done handshake lets the control unit stall while a long operation completes. Width is parametrised, and the CE input still gates all activity.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_seq_if.sv | 34 +++
 rtl/alu_muldiv_iter.sv | 93 +++++++++
 rtl/alu_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU and its
// iterative multiply/divide engine.
package alu_pkg;

  localparam int OP_W        = 4;
  localparam int ILLEGAL_MIN = 14;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_LD  = 4'd6,
    OP_ST  = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9,
    OP_ROL = 4'd10,
    OP_ROR = 4'd11,
    OP_MUL = 4'd12,
    OP_DIV = 4'd13
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the control unit (master) and the ALU (slave).
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int SIZE = 8
);

  logic            start;
  logic [OP_W-1:0] OP_CODE;
  logic [SIZE-1:0] left_operand;
  logic [SIZE-1:0] right_operand;
  logic            carry_in;

  logic            busy;
  logic            done;
  logic [SIZE-1:0] op_out;
  logic [SIZE-1:0] op_out_hi;
  logic            carry_out;
  logic            zero;
  logic            neg;
  logic            ovf;
  logic            err;

  modport master (
    output start, OP_CODE, left_operand, right_operand, carry_in,
    input  busy, done, op_out, op_out_hi, carry_out, zero, neg, ovf, err
  );

  modport slave (
    input  start, OP_CODE, left_operand, right_operand, carry_in,
    output busy, done, op_out, op_out_hi, carry_out, zero, neg, ovf, err
  );

endinterface

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle unsigned shift-add multiplier / restoring divider sharing
// a single {hi,lo} accumulator. res_hi/res_lo present the value after this cycle's step.
module alu_muldiv_iter #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            ce,
  input  logic            start,
  input  logic            div_sel,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            busy,
  output logic            finish,
  output logic            div_mode,
  output logic [SIZE-1:0] res_hi,
  output logic [SIZE-1:0] res_lo
);

  localparam int CNT_W = $clog2(SIZE);

  logic [SIZE-1:0]  hi_reg;
  logic [SIZE-1:0]  lo_reg;
  logic [SIZE-1:0]  b_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic             div_reg;

  logic [SIZE-1:0]  hi_next;
  logic [SIZE-1:0]  lo_next;
  logic [SIZE:0]    mul_sum;
  logic [SIZE:0]    div_shift;
  logic [SIZE:0]    div_diff;
  logic             q_bit;
  logic             last_step;

  always_comb begin
    hi_next   = hi_reg;
    lo_next   = lo_reg;
    q_bit     = 1'b0;
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
    div_shift = {hi_reg, lo_reg[SIZE-1]};
    div_diff  = div_shift - {1'b0, b_reg};
    if (div_reg) begin
      // Restoring step: keep the trial difference only when it does not go negative.
      if (div_shift >= {1'b0, b_reg}) begin
        q_bit   = 1'b1;
        hi_next = div_diff[SIZE-1:0];
      end else begin
        hi_next = div_shift[SIZE-1:0];
      end
      lo_next = {lo_reg[SIZE-2:0], q_bit};
    end else begin
      hi_next = mul_sum[SIZE:1];
      lo_next = {mul_sum[0], lo_reg[SIZE-1:1]};
    end
  end

  assign last_step = (cnt_reg == CNT_W'(SIZE - 1));
  assign finish    = busy_reg && ce && last_step;
  assign busy      = busy_reg;
  assign div_mode  = div_reg;
  assign res_hi    = hi_next;
  assign res_lo    = lo_next;

  always_ff @(posedge clk) begin
    if (srst) begin
      hi_reg   <= '0;
      lo_reg   <= '0;
      b_reg    <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      div_reg  <= 1'b0;
    end else if (ce) begin
      if (start) begin
        hi_reg   <= '0;
        lo_reg   <= a;
        b_reg    <= b;
        cnt_reg  <= '0;
        busy_reg <= 1'b1;
        div_reg  <= div_sel;
      end else if (busy_reg) begin
        hi_reg  <= hi_next;
        lo_reg  <= lo_next;
        cnt_reg <= cnt_reg + CNT_W'(1);
        if (last_step) begin
          busy_reg <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU: single-cycle logic/arith/shift ops plus an optional
// iterative MUL/DIV engine, with a start/busy/done handshake gated by CE.
module alu_seq
  import alu_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter bit MULDIV_EN = 1'b1
) (
  input logic      CLK,
  input logic      RST,
  input logic      CE,
  alu_seq_if.slave bus
);

  localparam int MSB = SIZE - 1;

  state_t          state_reg, state_next;
  logic [SIZE-1:0] op_out_reg, op_out_next;
  logic [SIZE-1:0] hi_reg, hi_next;
  logic            carry_reg, carry_next;
  logic            zero_reg, zero_next;
  logic            neg_reg, neg_next;
  logic            ovf_reg, ovf_next;
  logic            err_reg, err_next;
  logic            done_reg, done_next;

  logic [OP_W-1:0] op;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            muldiv_op;
  logic            illegal_op;
  logic            div_zero;
  logic            accept;
  logic            iter_start;

  logic            iter_busy;
  logic            iter_finish;
  logic            iter_div;
  logic [SIZE-1:0] iter_hi;
  logic [SIZE-1:0] iter_lo;

  logic [SIZE-1:0] b_eff;
  logic [SIZE:0]   sum_wide;
  logic [SIZE-1:0] sc_res;
  logic            sc_carry;
  logic            sc_ovf;

  assign op         = bus.OP_CODE;
  assign a          = bus.left_operand;
  assign b          = bus.right_operand;
  assign muldiv_op  = is_muldiv(op);
  assign illegal_op = (op >= OP_W'(ILLEGAL_MIN)) || (muldiv_op && !MULDIV_EN);
  assign div_zero   = (op == OP_DIV) && (b == '0);
  // FINISH is the done cycle and already counts as idle, allowing back-to-back issue.
  assign accept     = CE && bus.start && (state_reg != ST_EXEC);
  assign iter_start = accept && muldiv_op && !illegal_op && !div_zero;

  generate
    if (MULDIV_EN) begin : g_muldiv
      alu_muldiv_iter #(
        .SIZE(SIZE)
      ) u_iter (
        .clk     (CLK),
        .srst    (RST),
        .ce      (CE),
        .start   (iter_start),
        .div_sel (op == OP_DIV),
        .a       (a),
        .b       (b),
        .busy    (iter_busy),
        .finish  (iter_finish),
        .div_mode(iter_div),
        .res_hi  (iter_hi),
        .res_lo  (iter_lo)
      );
    end else begin : g_no_muldiv
      assign iter_busy   = 1'b0;
      assign iter_finish = 1'b0;
      assign iter_div    = 1'b0;
      assign iter_hi     = '0;
      assign iter_lo     = '0;
    end
  endgenerate

  // Single-cycle datapath; SUB is A + ~B + cin so cin acts as not-borrow.
  assign b_eff    = (op == OP_SUB) ? ~b : b;
  assign sum_wide = {1'b0, a} + {1'b0, b_eff} + {{SIZE{1'b0}}, bus.carry_in};

  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        sc_res   = sum_wide[SIZE-1:0];
        sc_carry = sum_wide[SIZE];
        sc_ovf   = (a[MSB] == b_eff[MSB]) && (sum_wide[MSB] != a[MSB]);
      end
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_XOR: sc_res = a ^ b;
      OP_NOT: sc_res = ~a;
      OP_LD:  sc_res = b;
      OP_ST:  sc_res = a;
      OP_SHL: begin
        sc_res   = {a[SIZE-2:0], 1'b0};
        sc_carry = a[MSB];
      end
      OP_SHR: begin
        sc_res   = {1'b0, a[SIZE-1:1]};
        sc_carry = a[0];
      end
      OP_ROL: begin
        sc_res   = {a[SIZE-2:0], bus.carry_in};
        sc_carry = a[MSB];
      end
      OP_ROR: begin
        sc_res   = {bus.carry_in, a[SIZE-1:1]};
        sc_carry = a[0];
      end
      default: begin
        sc_res   = '0;
        sc_carry = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    op_out_next = op_out_reg;
    hi_next     = hi_reg;
    carry_next  = carry_reg;
    zero_next   = zero_reg;
    neg_next    = neg_reg;
    ovf_next    = ovf_reg;
    err_next    = err_reg;
    done_next   = done_reg;
    if (CE) begin
      done_next = 1'b0;
      case (state_reg)
        ST_EXEC: begin
          if (iter_finish) begin
            state_next  = ST_FINISH;
            done_next   = 1'b1;
            op_out_next = iter_lo;
            hi_next     = iter_hi;
            carry_next  = iter_div ? 1'b0 : (|iter_hi);
            zero_next   = (iter_lo == '0);
            neg_next    = iter_lo[MSB];
            ovf_next    = 1'b0;
            err_next    = 1'b0;
          end
        end
        default: begin
          state_next = ST_IDLE;
          if (bus.start) begin
            if (illegal_op) begin
              done_next   = 1'b1;
              op_out_next = '0;
              hi_next     = '0;
              carry_next  = 1'b0;
              zero_next   = 1'b0;
              neg_next    = 1'b0;
              ovf_next    = 1'b0;
              err_next    = 1'b1;
            end else if (div_zero) begin
              done_next   = 1'b1;
              op_out_next = '1;
              hi_next     = a;
              carry_next  = 1'b0;
              zero_next   = 1'b0;
              neg_next    = 1'b1;
              ovf_next    = 1'b0;
              err_next    = 1'b1;
            end else if (muldiv_op) begin
              state_next = ST_EXEC;
            end else begin
              done_next   = 1'b1;
              op_out_next = sc_res;
              hi_next     = '0;
              carry_next  = sc_carry;
              zero_next   = (sc_res == '0);
              neg_next    = sc_res[MSB];
              ovf_next    = sc_ovf;
              err_next    = 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= ST_IDLE;
      op_out_reg <= '0;
      hi_reg     <= '0;
      carry_reg  <= 1'b0;
      zero_reg   <= 1'b0;
      neg_reg    <= 1'b0;
      ovf_reg    <= 1'b0;
      err_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      op_out_reg <= op_out_next;
      hi_reg     <= hi_next;
      carry_reg  <= carry_next;
      zero_reg   <= zero_next;
      neg_reg    <= neg_next;
      ovf_reg    <= ovf_next;
      err_reg    <= err_next;
      done_reg   <= done_next;
    end
  end

  // A pending done stays latched through a CE=0 stall and appears once CE returns.
  assign bus.done      = done_reg && CE;
  assign bus.busy      = iter_busy;
  assign bus.op_out    = op_out_reg;
  assign bus.op_out_hi = hi_reg;
  assign bus.carry_out = carry_reg;
  assign bus.zero      = zero_reg;
  assign bus.neg       = neg_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.err       = err_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (SIZE=8): vector table for every opcode plus
// hand sequences for CE stalls, ignored starts, reset abort and back-to-back issue.
module tb_alu_seq;

  logic CLK = 1'b0;
  logic RST;
  logic CE;

  alu_seq_if #(.SIZE(8)) bus ();

  alu_seq #(
    .SIZE     (8),
    .MULDIV_EN(1'b1)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .CE (CE),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] e_out;
    logic [7:0] e_hi;
    logic       e_c;
    logic       e_z;
    logic       e_n;
    logic       e_v;
    logic       e_e;
    int         e_lat;
    int         e_busy;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  logic [20:0] act_bundle;
  assign act_bundle = {bus.op_out_hi, bus.op_out, bus.carry_out, bus.zero,
                       bus.neg, bus.ovf, bus.err};

  function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic cin, input logic [7:0] e_out, input logic [7:0] e_hi,
                              input logic e_c, input logic e_z, input logic e_n,
                              input logic e_v, input logic e_e, input int e_lat, input int e_busy);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.cin = cin;
    v.e_out = e_out; v.e_hi = e_hi;
    v.e_c = e_c; v.e_z = e_z; v.e_n = e_n; v.e_v = e_v; v.e_e = e_e;
    v.e_lat = e_lat; v.e_busy = e_busy;
    return v;
  endfunction

  function automatic logic [20:0] exp_bundle(input vec_t v);
    return {v.e_hi, v.e_out, v.e_c, v.e_z, v.e_n, v.e_v, v.e_e};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic cin);
    bus.OP_CODE       = op;
    bus.left_operand  = a;
    bus.right_operand = b;
    bus.carry_in      = cin;
  endtask

  vec_t vecs[$];

  initial begin
    int lat;
    int busy_n;
    int done_n;
    logic [20:0] snap;

    vecs.push_back(mk(4'd0,  8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(4'd1,  8'h80, 8'h01, 1'b1, 8'h7F, 8'h00, 1, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(4'd11, 8'h01, 8'h00, 1'b1, 8'h80, 8'h00, 1, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(4'd0,  8'h01, 8'h01, 1'b1, 8'h03, 8'h00, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(4'd0,  8'h7F, 8'h01, 1'b0, 8'h80, 8'h00, 0, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(4'd1,  8'h05, 8'h07, 1'b1, 8'hFE, 8'h00, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(4'd2,  8'hF0, 8'h3C, 1'b1, 8'h30, 8'h00, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(4'd3,  8'hF0, 8'h0F, 1'b0, 8'hFF, 8'h00, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(4'd4,  8'hAA, 8'hFF, 1'b0, 8'h55, 8'h00, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(4'd5,  8'h0F, 8'h00, 1'b1, 8'hF0, 8'h00, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(4'd6,  8'h12, 8'h34, 1'b0, 8'h34, 8'h00, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(4'd7,  8'h12, 8'h34, 1'b0, 8'h12, 8'h00, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(4'd8,  8'h81, 8'h00, 1'b0, 8'h02, 8'h00, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(4'd9,  8'h81, 8'h00, 1'b0, 8'h40, 8'h00, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(4'd10, 8'h80, 8'h00, 1'b0, 8'h00, 8'h00, 1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(4'd10, 8'h80, 8'h00, 1'b1, 8'h01, 8'h00, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(4'd13, 8'h09, 8'h00, 1'b0, 8'hFF, 8'h09, 0, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(4'd14, 8'h05, 8'h03, 1'b0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(4'd15, 8'hAA, 8'h55, 1'b1, 8'h00, 8'h00, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(4'd12, 8'h0F, 8'h11, 1'b0, 8'hFF, 8'h00, 0, 0, 1, 0, 0, 9, 8));
    vecs.push_back(mk(4'd12, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 1, 0, 0, 0, 0, 9, 8));
    vecs.push_back(mk(4'd12, 8'h00, 8'h37, 1'b0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 9, 8));
    vecs.push_back(mk(4'd13, 8'd200, 8'd7, 1'b0, 8'h1C, 8'h04, 0, 0, 0, 0, 0, 9, 8));
    vecs.push_back(mk(4'd13, 8'h05, 8'h09, 1'b0, 8'h00, 8'h05, 0, 1, 0, 0, 0, 9, 8));
    vecs.push_back(mk(4'd13, 8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00, 0, 0, 1, 0, 0, 9, 8));

    // Reset with a live request: RST must win over CE and start.
    CE = 1'b1;
    RST = 1'b1;
    bus.start = 1'b1;
    drive(4'd0, 8'hFF, 8'h01, 1'b0);
    repeat (3) tick();
    check("reset_outputs", 64'(act_bundle), 64'(0));
    check("reset_done_busy", 64'({bus.done, bus.busy}), 64'(0));
    RST = 1'b0;
    bus.start = 1'b0;
    tick();
    check("post_reset_done", 64'(bus.done), 64'(0));

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      lat = 1;
      busy_n = 0;
      while (!bus.done && lat < 30) begin
        if (bus.busy) busy_n++;
        tick();
        lat++;
      end
      $display("vec %0d op=%0d a=%h b=%h cin=%0d -> out=%h hi=%h c=%0d z=%0d n=%0d v=%0d e=%0d lat=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, bus.op_out, bus.op_out_hi,
               bus.carry_out, bus.zero, bus.neg, bus.ovf, bus.err, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].e_lat));
      check($sformatf("vec%0d_busy_cycles", i), 64'(busy_n), 64'(vecs[i].e_busy));
      check($sformatf("vec%0d_result", i), 64'({bus.busy, act_bundle}),
            64'({1'b0, exp_bundle(vecs[i])}));
      tick();
      check($sformatf("vec%0d_hold", i), 64'({bus.done, act_bundle}),
            64'({1'b0, exp_bundle(vecs[i])}));
    end

    // MUL with a 3-cycle CE stall: done slips by exactly 3 cycles, outputs frozen.
    drive(4'd12, 8'h0F, 8'h11, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 1;
    repeat (3) begin
      tick();
      lat++;
    end
    snap = act_bundle;
    CE = 1'b0;
    repeat (3) begin
      tick();
      lat++;
      check("stall_frozen", 64'({bus.done, bus.busy, act_bundle}), 64'({2'b01, snap}));
    end
    CE = 1'b1;
    while (!bus.done && lat < 40) begin
      tick();
      lat++;
    end
    $display("stall mul 0f*11 -> out=%h hi=%h lat=%0d", bus.op_out, bus.op_out_hi, lat);
    check("stall_latency", 64'(lat), 64'(12));
    check("stall_result", 64'(act_bundle), 64'({8'h00, 8'hFF, 5'b00100}));

    // A start while busy is dropped: exactly one done, carrying the MUL result.
    tick();
    drive(4'd12, 8'h03, 8'h05, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    drive(4'd0, 8'h01, 8'h01, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    done_n = 0;
    snap = '0;
    repeat (15) begin
      if (bus.done) begin
        done_n++;
        snap = act_bundle;
      end
      tick();
    end
    $display("busy start mul 03*05 -> dones=%0d out=%h", done_n, snap[12:5]);
    check("ignored_start_done_count", 64'(done_n), 64'(1));
    check("ignored_start_result", 64'(snap), 64'({8'h00, 8'h0F, 5'b00000}));

    // Reset in the middle of a MUL aborts it with no done.
    drive(4'd12, 8'hFF, 8'hFF, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("abort_outputs", 64'({bus.done, bus.busy, act_bundle}), 64'(0));
    done_n = 0;
    repeat (12) begin
      tick();
      if (bus.done) done_n++;
    end
    $display("reset mid mul -> dones=%0d out=%h", done_n, bus.op_out);
    check("abort_no_done", 64'(done_n), 64'(0));

    // Back-to-back: AND issued in the MUL done cycle completes on the next cycle.
    drive(4'd12, 8'h0F, 8'h11, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 30) begin
      tick();
      lat++;
    end
    check("b2b_mul_latency", 64'(lat), 64'(9));
    check("b2b_mul_result", 64'(act_bundle), 64'({8'h00, 8'hFF, 5'b00100}));
    drive(4'd2, 8'hF0, 8'h3C, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    $display("b2b and f0&3c -> done=%0d out=%h", bus.done, bus.op_out);
    check("b2b_and_done", 64'({bus.done, bus.busy}), 64'(2'b10));
    check("b2b_and_result", 64'(act_bundle), 64'({8'h00, 8'h30, 5'b00000}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
